// File: rtl/audio_ram_arbiter.sv
// Arbiter for the single-port 8Kx16 ADPCM sample RAM shared by the CD sector
// writer, the audio decoder read port and the host CPU. One access in flight.
module audio_ram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [12:0] sec_addr,
  input  logic [15:0] sec_data,
  input  logic        sec_wr,
  output logic        sec_ack,
  input  logic [12:0] dec_addr,
  input  logic        dec_rd,
  output logic [15:0] dec_data,
  output logic        dec_ack,
  output logic        dec_ack_q,
  input  logic [12:0] host_addr,
  input  logic [15:0] host_wdata,
  input  logic [1:0]  host_be,
  input  logic        host_rd,
  input  logic        host_wr,
  output logic [15:0] host_rdata,
  output logic        host_ack,
  output logic [12:0] ram_addr,
  output logic [1:0]  ram_we,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_ACK = 2'd2} state_t;
  typedef enum logic [1:0] {REQ_SEC = 2'd0, REQ_DEC = 2'd1, REQ_HOST = 2'd2} req_t;

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  state_t      state_r, state_s;
  req_t        id_r, win_s;
  logic        grant_s, host_req_s, wr_r, wr_s;
  logic [2:0]  starve_r, starve_s;
  logic [12:0] sel_addr_s;
  logic [15:0] sel_wdata_s;
  logic [1:0]  sel_we_s;
  logic [12:0] ram_addr_r;
  logic [15:0] ram_wdata_r;
  logic [1:0]  ram_we_r;
  logic        sec_ack_r, dec_ack_r, dec_ack_q_r, host_ack_r;
  logic [15:0] dec_data_r, host_rdata_r;

  // Winner selection; only IDLE arbitrates, a starved host overrides priority.
  always_comb begin
    host_req_s = host_rd | host_wr;
    grant_s    = 1'b0;
    win_s      = REQ_SEC;
    if (state_r != ST_IDLE) begin
      grant_s = 1'b0;
    end else if (host_req_s && (starve_r == STARVE_MAX)) begin
      grant_s = 1'b1;
      win_s   = REQ_HOST;
    end else if (sec_wr) begin
      grant_s = 1'b1;
      win_s   = REQ_SEC;
    end else if (dec_rd) begin
      grant_s = 1'b1;
      win_s   = REQ_DEC;
    end else if (host_req_s) begin
      grant_s = 1'b1;
      win_s   = REQ_HOST;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Starvation counter: counts host losses in IDLE, saturating at the limit.
  always_comb begin
    starve_s = starve_r;
    if (state_r != ST_IDLE) begin
      starve_s = starve_r;
    end else if (!host_req_s || (win_s == REQ_HOST)) begin
      starve_s = 3'd0;
    end else if (starve_r < STARVE_MAX) begin
      starve_s = starve_r + 3'd1;
    end else begin
      starve_s = starve_r;
    end
  end

  // Payload of the winning requester; read+write from the host counts as a write.
  always_comb begin
    sel_addr_s  = sec_addr;
    sel_wdata_s = sec_data;
    sel_we_s    = 2'b11;
    wr_s        = 1'b1;
    case (win_s)
      REQ_SEC: begin
        sel_addr_s  = sec_addr;
        sel_wdata_s = sec_data;
        sel_we_s    = 2'b11;
        wr_s        = 1'b1;
      end
      REQ_DEC: begin
        sel_addr_s  = dec_addr;
        sel_wdata_s = 16'h0000;
        sel_we_s    = 2'b00;
        wr_s        = 1'b0;
      end
      REQ_HOST: begin
        sel_addr_s  = host_addr;
        sel_wdata_s = host_wdata;
        sel_we_s    = host_wr ? host_be : 2'b00;
        wr_s        = host_wr;
      end
      default: begin
        sel_addr_s  = sec_addr;
        sel_wdata_s = sec_data;
        sel_we_s    = 2'b00;
        wr_s        = 1'b0;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_s = ST_ACK;
      ST_ACK:    state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State and starvation registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      starve_r <= 3'd0;
    end else begin
      state_r  <= state_s;
      starve_r <= starve_s;
    end
  end

  // Grant latch and RAM port; write enable lives only in the ACCESS cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_r        <= REQ_SEC;
      wr_r        <= 1'b0;
      ram_addr_r  <= 13'h0000;
      ram_wdata_r <= 16'h0000;
      ram_we_r    <= 2'b00;
    end else begin
      ram_we_r <= grant_s ? sel_we_s : 2'b00;
      if (grant_s) begin
        id_r        <= win_s;
        wr_r        <= wr_s;
        ram_addr_r  <= sel_addr_s;
        ram_wdata_r <= sel_wdata_s;
      end
    end
  end

  // Ack pulses cover the ACK cycle; read data is held after its ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_ack_r    <= 1'b0;
      dec_ack_r    <= 1'b0;
      dec_ack_q_r  <= 1'b0;
      host_ack_r   <= 1'b0;
      dec_data_r   <= 16'h0000;
      host_rdata_r <= 16'h0000;
    end else begin
      sec_ack_r   <= (state_r == ST_ACCESS) && (id_r == REQ_SEC);
      dec_ack_r   <= (state_r == ST_ACCESS) && (id_r == REQ_DEC);
      host_ack_r  <= (state_r == ST_ACCESS) && (id_r == REQ_HOST);
      dec_ack_q_r <= dec_ack_r;
      if (dec_ack_r) begin
        dec_data_r <= ram_rdata;
      end
      if (host_ack_r && !wr_r) begin
        host_rdata_r <= ram_rdata;
      end
    end
  end

  // RAM data arrives during the ACK cycle, so it is forwarded while acked.
  assign dec_data   = dec_ack_r ? ram_rdata : dec_data_r;
  assign host_rdata = (host_ack_r && !wr_r) ? ram_rdata : host_rdata_r;
  assign sec_ack    = sec_ack_r;
  assign dec_ack    = dec_ack_r;
  assign dec_ack_q  = dec_ack_q_r;
  assign host_ack   = host_ack_r;
  assign ram_addr   = ram_addr_r;
  assign ram_we     = ram_we_r;
  assign ram_wdata  = ram_wdata_r;

endmodule
